// File: rtl/longlat_issue_ctrl.sv
// ---------------------------------------------------------------------------
// longlat_issue_ctrl
//
// Issue/completion controller for the shared iterative long-latency unit
// (int DIV/REM, FP FDIV/FSQRT). It accepts one op from EXE and starts the
// unit. It tracks the pending destination register and its file (int or FP).
// While the op is outstanding it stalls the ID stage on RAW/WAW hazards.
// When the unit finishes, the controller injects the result into the WB port
// for exactly one cycle.
//
// Ports
//   clk, reset             core clock, synchronous active-high reset
//   issue_valid/rd/fp_dest EXE offers a long-latency op and its destination
//   issue_ready            controller accepts the op this cycle
//   flush                  pipeline flush; kills the in-flight op
//   unit_start             one-cycle start pulse to the iterative unit
//   unit_done              one-cycle completion pulse from the unit
//   rs1/rs2/rs3_id         ID-stage sources; rs1/rs2_fp_id select the file
//                          (rs3 always reads the FP file)
//   rd_id, reg_write_id,   ID-stage destination and its write enables
//   FP_reg_write_id
//   stall_id               freeze IF/ID and insert a bubble into EXE
//   hold_wb                freeze MEM/WB; the WB port is taken this cycle
//   ll_wb_valid/rd/fp      long-latency result write into the register file
//   busy                   controller is not idle
//   err_timeout            sticky; set when the unit overruns TIMEOUT cycles
// ---------------------------------------------------------------------------
module longlat_issue_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    input  logic [4:0] issue_rd,
    input  logic       issue_fp_dest,
    output logic       issue_ready,
    input  logic       flush,
    output logic       unit_start,
    input  logic       unit_done,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic [4:0] rs3_id,
    input  logic       rs1_fp_id,
    input  logic       rs2_fp_id,
    input  logic [4:0] rd_id,
    input  logic       reg_write_id,
    input  logic       FP_reg_write_id,
    output logic       stall_id,
    output logic       hold_wb,
    output logic       ll_wb_valid,
    output logic [4:0] ll_wb_rd,
    output logic       ll_wb_fp,
    output logic       busy,
    output logic       err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_WB    = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       pend_rd_q;
    logic             pend_fp_q;
    logic             start_q;
    logic             wb_valid_q;
    logic [4:0]       wb_rd_q;
    logic             wb_fp_q;
    logic             busy_q;
    logic             err_q;

    logic             hz_window;
    logic             pend_is_x0;
    logic             raw_hit;
    logic             waw_hit;
    logic             struct_hit;

    assign issue_ready = (state_q == S_IDLE) & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pend_rd_q  <= '0;
            pend_fp_q  <= 1'b0;
            start_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_fp_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Pulsed outputs default low; they are raised only on the
            // transition that owns them.
            start_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_fp_q    <= 1'b0;

            // Sticky watchdog: independent of whatever transition BUSY takes.
            if (state_q == S_BUSY && cnt_q == CNT_MAX) begin
                err_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    // A late unit_done from an op aborted by reset lands
                    // here and is deliberately ignored.
                    if (issue_valid && issue_ready) begin
                        pend_rd_q <= issue_rd;
                        pend_fp_q <= issue_fp_dest;
                        start_q   <= 1'b1;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (unit_done && !flush) begin
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= pend_rd_q;
                        wb_fp_q    <= pend_fp_q;
                        state_q    <= S_WB;
                    end else if (unit_done && flush) begin
                        // Unit finished as the op was killed: drop the result.
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (flush) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_WB: begin
                    // Result is already committed; a flush here has no effect.
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_DRAIN: begin
                    // Unit cannot be aborted, so wait out its completion.
                    if (unit_done) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Hazards only matter while a result is still owed to the register file.
    // In DRAIN the op is dead, so nothing will be written.
    assign hz_window  = (state_q == S_BUSY) || (state_q == S_WB);
    assign pend_is_x0 = ~pend_fp_q & (pend_rd_q == 5'd0);

    assign raw_hit = ((rs1_id == pend_rd_q) & (rs1_fp_id == pend_fp_q))
                   | ((rs2_id == pend_rd_q) & (rs2_fp_id == pend_fp_q))
                   | ((rs3_id == pend_rd_q) & pend_fp_q);

    assign waw_hit = ((reg_write_id & ~pend_fp_q) | (FP_reg_write_id & pend_fp_q))
                   & (rd_id == pend_rd_q);

    assign struct_hit = issue_valid & ~issue_ready;

    assign stall_id = hz_window & (((raw_hit | waw_hit) & ~pend_is_x0) | struct_hit);

    assign unit_start  = start_q;
    assign ll_wb_valid = wb_valid_q;
    assign hold_wb     = wb_valid_q;
    assign ll_wb_rd    = wb_rd_q;
    assign ll_wb_fp    = wb_fp_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

endmodule
